imem_loader: RTL

//  Writer side of the instruction memory: receives a program image as a byte stream
//  (valid/ready) and writes 32-bit words into instruction memory at word addresses 0..N-1.

---
 rtl/imem_loader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: framed byte stream in, 32-bit imem writes out.
// Holds the core in reset until a complete frame with a matching checksum lands.
module imem_loader #(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic              load_wr_o,
    output logic [ADDR_W-1:0] load_addr_o,
    output logic [31:0]       load_data_o,
    output logic              core_rst_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W:0]   word_count_o
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [16:0]   MAX_N  = 17'(1) << ADDR_W;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERR
    } state_t;

    state_t        state;
    logic [7:0]    len_hi;
    logic [15:0]   len;
    logic [23:0]   shreg;
    logic [1:0]    bidx;
    logic [7:0]    checksum;
    logic [TW-1:0] timer;

    logic          accept;
    logic [16:0]   n_words;
    logic          last_word;

    assign accept    = byte_valid_i & byte_ready_o;
    assign n_words   = {1'b0, len_hi, byte_i};
    // Word count only advances after the write pulse, so it still names this word
    assign last_word = (17'(word_count_o) == (17'(len) - 17'd1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            byte_ready_o <= 1'b0;
            load_wr_o    <= 1'b0;
            load_addr_o  <= '0;
            load_data_o  <= '0;
            core_rst_o   <= 1'b1;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            word_count_o <= '0;
            len_hi       <= '0;
            len          <= '0;
            shreg        <= '0;
            bidx         <= '0;
            checksum     <= '0;
            timer        <= '0;
        end else begin
            load_wr_o <= 1'b0;
            if (load_wr_o) begin
                word_count_o <= word_count_o + 1'b1;
            end
            unique case (state)
                IDLE, DONE, ERR: begin
                    if (start_i) begin
                        state        <= LEN_HI;
                        byte_ready_o <= 1'b1;
                        core_rst_o   <= 1'b1;
                        busy_o       <= 1'b1;
                        done_o       <= 1'b0;
                        err_o        <= 1'b0;
                        word_count_o <= '0;
                        load_addr_o  <= '0;
                        checksum     <= '0;
                        timer        <= '0;
                        bidx         <= '0;
                    end
                end
                LEN_HI, LEN_LO, DATA, CHECK: begin
                    if (accept) begin
                        timer <= '0;
                        case (state)
                            LEN_HI: begin
                                len_hi <= byte_i;
                                state  <= LEN_LO;
                            end
                            LEN_LO: begin
                                len <= n_words[15:0];
                                if (n_words != 17'd0 && n_words <= MAX_N) begin
                                    state <= DATA;
                                end else begin
                                    state        <= ERR;
                                    byte_ready_o <= 1'b0;
                                    busy_o       <= 1'b0;
                                    err_o        <= 1'b1;
                                end
                            end
                            DATA: begin
                                checksum <= checksum ^ byte_i;
                                shreg    <= {shreg[15:0], byte_i};
                                bidx     <= bidx + 2'd1;
                                if (bidx == 2'd3) begin
                                    load_wr_o   <= 1'b1;
                                    load_addr_o <= word_count_o[ADDR_W-1:0];
                                    load_data_o <= {shreg, byte_i};
                                    if (last_word) begin
                                        state <= CHECK;
                                    end
                                end
                            end
                            CHECK: begin
                                byte_ready_o <= 1'b0;
                                busy_o       <= 1'b0;
                                if (byte_i == checksum) begin
                                    state      <= DONE;
                                    done_o     <= 1'b1;
                                    core_rst_o <= 1'b0;
                                end else begin
                                    state <= ERR;
                                    err_o <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end else if (timer == T_LAST) begin
                        state        <= ERR;
                        byte_ready_o <= 1'b0;
                        busy_o       <= 1'b0;
                        err_o        <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    byte_ready_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
